dbus_arbiter: RTL and testbench
===============================

DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 SHALL have parameter RR_MODE, default 0, meaning 0 = fixed priority to port 0 (data) and 1 = round-robin on ties.
REQ-002 SHALL have port clk  input  1  system clock, all state rising-edge.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port m0_req  input  dbus_req_t  memory-stage (data) request.
REQ-005 SHALL have port m0_resp  output  dbus_resp_t  response to port 0.
REQ-006 SHALL have port m1_req  input  dbus_req_t  fetch (instruction) request, in dbus format.
REQ-007 SHALL have port m1_resp  output  dbus_resp_t  response to port 1.
REQ-008 SHALL have port out_req  output  dbus_req_t  single shared downstream request.
REQ-009 SHALL have port out_resp  input  dbus_resp_t  downstream response.

Function
REQ-010 SHALL implement states IDLE, ADDR and DATA, with exactly one downstream transaction outstanding.
REQ-011 SHALL stay in IDLE while neither m0_req.valid nor m1_req.valid is set.
REQ-012 SHALL, in IDLE with at least one valid request, select a winner, latch its full request (addr, size, strobe, data) into a holding register, record grant_id and enter ADDR next cycle.
REQ-013 SHALL grant a lone valid requester in IDLE immediately.
REQ-014 SHALL resolve ties as follows:
- RR_MODE=0: grant port 0.
- RR_MODE=1: grant the port not equal to last_grant, then update last_grant.
REQ-015 SHALL drive out_req from the holding register only, with out_req.valid=1 in ADDR and out_req=0 in IDLE and DATA.
REQ-016 SHALL, in ADDR with out_resp.addr_ok=1, drive addr_ok=1 on the granted port's resp in the same cycle (combinational pass-through).
REQ-017 SHALL, in ADDR with addr_ok=1 and data_ok=0, move to DATA.
REQ-018 SHALL, in ADDR with addr_ok=1 and data_ok=1 in the same cycle, forward both plus data to the granted port that cycle and return to IDLE.
REQ-019 SHALL, in DATA with out_resp.data_ok=1, forward data_ok=1 and out_resp.data to the granted port that cycle and return to IDLE.
REQ-020 SHALL hold the non-granted port's resp at all-zero in every state, and every resp at zero in IDLE.
REQ-021 SHALL ignore out_resp.data_ok while in IDLE or ADDR-without-addr_ok (spurious response: no forwarding, no state change).
REQ-022 SHALL leave the holding register unchanged if the granted requester changes or drops valid after the grant; the latched transaction completes as issued.
REQ-023 SHALL give the minimum transaction latency: request valid in cycle t, out_req.valid in t+1, and earliest completion in t+1 (same-cycle addr_ok and data_ok).
REQ-024 SHALL re-arbitrate in the cycle after return to IDLE, giving a one-cycle gap between back-to-back transactions.
REQ-025 SHALL evaluate a waiting requester still holding valid in the same IDLE cycle as any new requester, with no queue beyond the two ports.

Reset
REQ-026 SHALL, on resetn=0 at any time (including mid-transaction), force state=IDLE, holding register=0, grant_id=0, last_grant=1 and all outputs to zero.
REQ-027 SHALL not complete an in-flight downstream transaction after reset; downstream is reset on the same resetn.
REQ-028 SHALL become operational on the first rising clk edge after resetn deasserts.

Verification
REQ-029 SHALL pass this scenario: lone m0 load addr 0x8000_0010 size MSIZE4, downstream gives addr_ok cycle 2 and data_ok cycle 4 with data 0xDEAD_BEEF -> m0_resp.addr_ok=1 cycle 2, m0_resp.data_ok=1 and data=0xDEAD_BEEF cycle 4, m1_resp stays 0.
REQ-030 SHALL pass this scenario: RR_MODE=0, m0 and m1 valid together for 3 transactions -> m0 is granted first, and m1 is granted only once m0 drops valid.
REQ-031 SHALL pass this scenario: RR_MODE=1, both held valid continuously -> grant order m0, m1, m0, m1 after reset.
REQ-032 SHALL pass this scenario: m1 store strobe 4'h3 data 0x0000_1234 with same-cycle addr_ok and data_ok -> single-cycle ADDR, return to IDLE, and out_req.strobe=4'h3 for that cycle only.
REQ-033 SHALL pass this scenario: resetn pulsed low in DATA -> all outputs 0 asynchronously, state IDLE, and a following lone m1 request granted first.
REQ-034 SHALL pass this scenario: data_ok=1 injected in IDLE -> no resp pulse on either port and no state change.

Source files
------------

// File: rtl/dbus_arbiter.sv
// ----------------------------------------------------------------------------
// dbus_pkg / dbus_arbiter
//
// Purpose : two-port to one-port data-bus arbiter. Port 0 carries memory-stage
//           (data) requests, port 1 carries fetch requests in the same dbus
//           format. Exactly one downstream transaction is outstanding at a
//           time: the winning request is copied into a holding register,
//           issued during ADDR, and its response is routed back to the port
//           that won.
//
// Ports   : clk      - system clock, all state on the rising edge
//           resetn   - asynchronous active-low reset
//           m0_req   - port 0 (data) request          m0_resp - port 0 response
//           m1_req   - port 1 (fetch) request         m1_resp - port 1 response
//           out_req  - shared downstream request      out_resp - downstream response
//
// Params  : RR_MODE  - 0: ties go to port 0; 1: ties go to the port that did
//                      not win last time.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

package dbus_pkg;
    localparam logic [2:0] MSIZE1 = 3'd0;
    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int unsigned RR_MODE = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  dbus_req_t  m0_req,
    output dbus_resp_t m0_resp,
    input  dbus_req_t  m1_req,
    output dbus_resp_t m1_resp,
    output dbus_req_t  out_req,
    input  dbus_resp_t out_resp
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t     r_state;
    dbus_req_t  r_hold;
    logic       r_grant_id;
    logic       r_last_grant;

    logic       w_any;
    logic       w_win;
    dbus_req_t  w_win_req;
    dbus_resp_t w_resp;

    // Arbitration: a lone requester always wins; a tie goes to port 0 or,
    // in round-robin mode, to the port that did not win the previous grant.
    always_comb begin
        w_any = m0_req.valid | m1_req.valid;
        if (m0_req.valid && m1_req.valid) begin
            w_win = (RR_MODE != 0) ? ~r_last_grant : 1'b0;
        end else begin
            w_win = ~m0_req.valid;
        end
        w_win_req = w_win ? m1_req : m0_req;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_hold       <= w_win_req;
                        r_grant_id   <= w_win;
                        r_last_grant <= w_win;
                        r_state      <= ADDR;
                    end
                end
                ADDR: begin
                    // data_ok without addr_ok is spurious and ignored here.
                    if (out_resp.addr_ok) begin
                        if (out_resp.data_ok) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (out_resp.data_ok) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The downstream request comes only from the holding register, so later
    // changes on the requesting port cannot disturb an issued transaction.
    always_comb begin
        out_req = '0;
        if (r_state == ADDR) begin
            out_req       = r_hold;
            out_req.valid = 1'b1;
        end
    end

    // Response pass-through, qualified by phase so stray handshakes never
    // reach either port.
    always_comb begin
        w_resp = '0;
        case (r_state)
            ADDR: begin
                w_resp.addr_ok = out_resp.addr_ok;
                if (out_resp.addr_ok && out_resp.data_ok) begin
                    w_resp.data_ok = 1'b1;
                    w_resp.data    = out_resp.data;
                end
            end
            DATA: begin
                if (out_resp.data_ok) begin
                    w_resp.data_ok = 1'b1;
                    w_resp.data    = out_resp.data;
                end
            end
            default: w_resp = '0;
        endcase
        m0_resp = r_grant_id ? '0 : w_resp;
        m1_resp = r_grant_id ? w_resp : '0;
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
`timescale 1ns/1ps

module tb_dbus_arbiter;
    import dbus_pkg::*;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    dbus_req_t  m0_req   = '0;
    dbus_req_t  m1_req   = '0;
    dbus_resp_t out_resp = '0;

    // Index 0: fixed-priority instance, index 1: round-robin instance.
    dbus_resp_t m0_resp [2];
    dbus_resp_t m1_resp [2];
    dbus_req_t  out_req [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dbus_arbiter #(.RR_MODE(0)) dut_fp (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_resp(m0_resp[0]),
        .m1_req(m1_req), .m1_resp(m1_resp[0]),
        .out_req(out_req[0]), .out_resp(out_resp)
    );

    dbus_arbiter #(.RR_MODE(1)) dut_rr (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_resp(m0_resp[1]),
        .m1_req(m1_req), .m1_resp(m1_resp[1]),
        .out_req(out_req[1]), .out_resp(out_resp)
    );

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference: per instance, is a transaction
    // outstanding, has its address been accepted, which port owns it,
    // and what exactly was captured when it was granted.
    // ------------------------------------------------------------------
    bit        m_busy [2] = '{0, 0};
    bit        m_acc  [2] = '{0, 0};
    int        m_port [2] = '{0, 0};
    int        m_last [2] = '{1, 1};
    dbus_req_t m_held [2] = '{'0, '0};

    always @(posedge clk or negedge resetn) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                m_busy[k] = 0;
                m_acc[k]  = 0;
                m_port[k] = 0;
                m_last[k] = 1;
                m_held[k] = '0;
            end else if (!m_busy[k]) begin
                if (m0_req.valid || m1_req.valid) begin
                    if (m0_req.valid && m1_req.valid)
                        m_port[k] = (k == 1) ? 1 - m_last[k] : 0;
                    else
                        m_port[k] = m0_req.valid ? 0 : 1;
                    m_held[k] = (m_port[k] == 0) ? m0_req : m1_req;
                    m_last[k] = m_port[k];
                    m_busy[k] = 1;
                    m_acc[k]  = 0;
                end
            end else if (!m_acc[k]) begin
                if (out_resp.addr_ok) begin
                    if (out_resp.data_ok) m_busy[k] = 0;
                    else                  m_acc[k]  = 1;
                end
            end else if (out_resp.data_ok) begin
                m_busy[k] = 0;
            end
        end
    end

    function automatic dbus_req_t exp_out(int k);
        dbus_req_t r = '0;
        if (m_busy[k] && !m_acc[k]) begin
            r       = m_held[k];
            r.valid = 1'b1;
        end
        return r;
    endfunction

    function automatic dbus_resp_t exp_resp(int k, int p);
        dbus_resp_t r = '0;
        if (m_busy[k] && m_port[k] == p) begin
            if (!m_acc[k]) begin
                r.addr_ok = out_resp.addr_ok;
                if (out_resp.addr_ok && out_resp.data_ok) begin
                    r.data_ok = 1'b1;
                    r.data    = out_resp.data;
                end
            end else if (out_resp.data_ok) begin
                r.data_ok = 1'b1;
                r.data    = out_resp.data;
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_out_req[%0d]", k), out_req[k], exp_out(k));
            chk($sformatf("model_m0_resp[%0d]", k), m0_resp[k], exp_resp(k, 0));
            chk($sformatf("model_m1_resp[%0d]", k), m1_resp[k], exp_resp(k, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int e0, e1, g0, g1;

    initial begin
        // Reset state
        #3;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_req", out_req[k], '0);
            chk("rst_m0_resp", m0_resp[k], '0);
            chk("rst_m1_resp", m1_resp[k], '0);
        end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Lone m0 load, addr_ok in cycle 2, data_ok in cycle 4
        tick();
        m0_req = '{valid: 1'b1, addr: 32'h8000_0010, size: MSIZE4, strobe: 4'h0, data: 32'h0};
        #2 chk("ld_idle_resp", m0_resp[0], '0);
        tick();
        m0_req.valid = 1'b0;
        m0_req.addr  = 32'h1234_5678;   // must not disturb the held request
        out_resp.addr_ok = 1'b1;
        #2;
        chk("ld_out_addr", out_req[0].addr, 32'h8000_0010);
        chk("ld_out_valid", out_req[0].valid, 1'b1);
        chk("ld_out_size", out_req[0].size, MSIZE4);
        chk("ld_addr_ok", m0_resp[0].addr_ok, 1'b1);
        chk("ld_m1_quiet", m1_resp[0], '0);
        tick();
        out_resp = '0;
        #2 chk("ld_data_phase_out", out_req[0], '0);
        tick();
        out_resp.data_ok = 1'b1;
        out_resp.data    = 32'hDEAD_BEEF;
        #2;
        chk("ld_data_ok", m0_resp[0].data_ok, 1'b1);
        chk("ld_data", m0_resp[0].data, 32'hDEAD_BEEF);
        chk("ld_m1_quiet2", m1_resp[0], '0);
        tick();
        out_resp = '0;
        #2 chk("ld_done_resp", m0_resp[0], '0);

        // Spurious data_ok while idle
        out_resp.data_ok = 1'b1;
        out_resp.data    = 32'hCAFE_F00D;
        #1;
        chk("spur_m0", m0_resp[0], '0);
        chk("spur_m1", m1_resp[0], '0);
        chk("spur_rr_m0", m0_resp[1], '0);
        tick();
        out_resp = '0;
        #2 chk("spur_still_idle", out_req[0], '0);

        // m1 store with same-cycle addr_ok and data_ok
        tick();
        m1_req = '{valid: 1'b1, addr: 32'h0000_0100, size: MSIZE4, strobe: 4'h3, data: 32'h0000_1234};
        tick();
        m1_req.valid = 1'b0;
        out_resp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0};
        #2;
        chk("st_strobe", out_req[0].strobe, 4'h3);
        chk("st_data", out_req[0].data, 32'h0000_1234);
        chk("st_m1_resp", m1_resp[0], {1'b1, 1'b1, 32'h0});
        chk("st_m0_quiet", m0_resp[0], '0);
        tick();
        out_resp = '0;
        #2;
        chk("st_strobe_gone", out_req[0].strobe, 4'h0);
        chk("st_valid_gone", out_req[0].valid, 1'b0);

        // Both ports contending: 3 transactions, then m0 drops
        tick();
        m0_req = '{valid: 1'b1, addr: 32'h0000_1000, size: MSIZE4, strobe: 4'h0, data: 32'h0};
        m1_req = '{valid: 1'b1, addr: 32'h0000_2000, size: MSIZE4, strobe: 4'h0, data: 32'h0};
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin
                out_resp.data_ok = 1'b1;   // ignored: no addr_ok yet
                #2;
                chk("wait_valid", out_req[0].valid, 1'b1);
                chk("wait_resp", m0_resp[0], '0);
                tick();
                out_resp = '0;
            end
            g0 = (i < 3) ? 0 : 1;
            g1 = (i == 3) ? 1 : (i % 2);
            e0 = (g0 == 0) ? 32'h1000 : 32'h2000;
            e1 = (g1 == 0) ? 32'h1000 : 32'h2000;
            out_resp.addr_ok = 1'b1;
            #2;
            chk($sformatf("fp_grant%0d", i), out_req[0].addr, e0);
            chk($sformatf("rr_grant%0d", i), out_req[1].addr, e1);
            tick();
            out_resp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'hA0 + i};
            #2;
            chk($sformatf("fp_data%0d", i), (g0 == 0) ? m0_resp[0].data : m1_resp[0].data, 32'hA0 + i);
            chk($sformatf("rr_data%0d", i), (g1 == 0) ? m0_resp[1].data : m1_resp[1].data, 32'hA0 + i);
            chk($sformatf("rr_other%0d", i), (g1 == 0) ? m1_resp[1] : m0_resp[1], '0);
            tick();
            out_resp = '0;
            #2 chk($sformatf("gap%0d", i), out_req[1], '0);
            if (i == 2) m0_req.valid = 1'b0;
            if (i == 3) m1_req.valid = 1'b0;
        end

        // Reset pulse while in DATA
        tick();
        m0_req = '{valid: 1'b1, addr: 32'h0000_3000, size: MSIZE4, strobe: 4'h0, data: 32'h0};
        tick();
        m0_req.valid = 1'b0;
        out_resp.addr_ok = 1'b1;
        tick();
        out_resp = '0;
        #1 resetn = 1'b0;
        out_resp.data_ok = 1'b1;
        out_resp.data    = 32'h5555_5555;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("arst_out_req", out_req[k], '0);
            chk("arst_m0_resp", m0_resp[k], '0);
            chk("arst_m1_resp", m1_resp[k], '0);
        end
        tick();
        resetn   = 1'b1;
        out_resp = '0;
        m1_req = '{valid: 1'b1, addr: 32'h0000_4000, size: MSIZE4, strobe: 4'h0, data: 32'h0};
        tick();
        m1_req.valid = 1'b0;
        out_resp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h77};
        #2;
        chk("post_rst_fp_addr", out_req[0].addr, 32'h0000_4000);
        chk("post_rst_rr_addr", out_req[1].addr, 32'h0000_4000);
        chk("post_rst_m1_resp", m1_resp[0], {1'b1, 1'b1, 32'h77});
        chk("post_rst_m0_quiet", m0_resp[0], '0);
        tick();
        out_resp = '0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
